// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_reg
// Description : EX/MEM pipeline register with stall, bubble insertion, flush
//               and a valid flag. It also returns the multi-cycle accumulate
//               state (madd/msub partial product and step count) to execute.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_ex,
    input  logic                  stall_mem,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  ex_whilo,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [CNT_W-1:0]      cnt_i,
    output logic [ADDR_W-1:0]     mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_whilo,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]     mem_mem_addr,
    output logic [DATA_W-1:0]     mem_reg2,
    output logic                  mem_valid,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [CNT_W-1:0]      cnt_o
);

    // Payload update decode. Reset and flush both force the NOP state; a
    // memory-stage stall freezes the payload; an execute-stage stall alone
    // inserts a bubble so the stalled instruction is never duplicated.
    logic w_clear;
    logic w_hold;
    logic w_bubble;

    assign w_clear  = !rst || flush;
    assign w_hold   = stall_mem;
    assign w_bubble = stall_ex && !stall_mem;

    // Control fields: write enables and the valid flag.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            mem_wreg  <= 1'b0;
            mem_whilo <= 1'b0;
            mem_valid <= 1'b0;
        end else if (w_hold) begin
            mem_wreg  <= mem_wreg;
            mem_whilo <= mem_whilo;
            mem_valid <= mem_valid;
        end else if (w_bubble) begin
            mem_wreg  <= 1'b0;
            mem_whilo <= 1'b0;
            mem_valid <= 1'b0;
        end else begin
            mem_wreg  <= ex_wreg;
            mem_whilo <= ex_whilo;
            mem_valid <= 1'b1;
        end
    end

    // Data fields: destination, results, opcode and load/store operands.
    always_ff @(posedge clk) begin
        if (w_clear || w_bubble) begin
            mem_wd       <= '0;
            mem_wdata    <= '0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
        end else if (!w_hold) begin
            mem_wd       <= ex_wd;
            mem_wdata    <= ex_wdata;
            mem_hi       <= ex_hi;
            mem_lo       <= ex_lo;
            mem_aluop    <= ex_aluop;
            mem_mem_addr <= ex_mem_addr;
            mem_reg2     <= ex_reg2;
        end
    end

    // Accumulate state: follows execute while it is stalled in a multi-cycle
    // op and returns to zero on the releasing edge, independent of stall_mem.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            hilo_o <= '0;
            cnt_o  <= '0;
        end else if (stall_ex) begin
            hilo_o <= hilo_i;
            cnt_o  <= cnt_i;
        end else begin
            hilo_o <= '0;
            cnt_o  <= '0;
        end
    end

endmodule
`default_nettype wire

// File: doc/ex_mem_reg.md
# ex_mem_reg

Parametrised EX/MEM pipeline register. It sits between the execute and memory-access stages of the five-stage core and carries the register-write, HI/LO-write and load/store payload. It also carries the multi-cycle accumulate state (madd/msub partial product and cycle count) back to execute. It adds stall, bubble insertion, flush and a valid flag, none of which the plain pass-through register has.

## Interface
Parameters:
- DATA_W, 32, width of data, HI, LO and memory-address fields
- ADDR_W, 5, register-file address width
- ALUOP_W, 8, ALU opcode width
- CNT_W, 2, multi-cycle counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk)
- stall_ex  in  1  execute stage is stalled
- stall_mem  in  1  memory stage is stalled
- flush  in  1  discard register contents (exception/redirect)
- ex_wd  in  ADDR_W  destination register
- ex_wreg  in  1  register write enable
- ex_wdata  in  DATA_W  register write data
- ex_whilo  in  1  HI/LO write enable
- ex_hi, ex_lo  in  DATA_W each  HI/LO write data
- ex_aluop  in  ALUOP_W  opcode, used by memory stage for load/store decode
- ex_mem_addr  in  DATA_W  effective address
- ex_reg2  in  DATA_W  store data
- hilo_i  in  2*DATA_W  partial accumulate result from execute
- cnt_i  in  CNT_W  multi-cycle step count from execute
- mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2  out  (widths as inputs)  registered payload to memory stage
- mem_valid  out  1  payload holds a real instruction
- hilo_o  out  2*DATA_W  accumulate state returned to execute
- cnt_o  out  CNT_W  step count returned to execute

## Operation
- Control fields are mem_wreg, mem_whilo and mem_valid. Data fields are all other mem_* outputs.
- Priority on each rising edge, highest first:
  1. rst=0: every output cleared to zero. This is the NOP state: mem_wd=0, mem_wreg=0, mem_whilo=0, mem_aluop=0, mem_valid=0, hilo_o=0, cnt_o=0.
  2. flush=1: every mem_* output and mem_valid cleared to zero; hilo_o=0, cnt_o=0.
  3. stall_mem=1: all mem_* outputs and mem_valid hold their values.
  4. stall_ex=1, stall_mem=0 (bubble): mem_* outputs cleared to NOP, mem_valid=0. The instruction held in execute is not duplicated into memory.
  5. stall_ex=0, stall_mem=0 (advance): every ex_* input is captured into the matching mem_* output, and mem_valid=1.
- Accumulate path (hilo_o, cnt_o), when neither rst nor flush is active:
  - stall_ex=1: capture hilo_i and cnt_i, regardless of stall_mem.
  - stall_ex=0: clear both to 0, ending the multi-cycle op.
- stall_ex=0 with stall_mem=1 is legal. Payload holds per rule 3; the accumulate path clears.
- No combinational path from any input to any output.
- Widths are fixed by parameters. No truncation or extension occurs inside the block.

## Timing
- Latency: one cycle, ex_* to mem_*.
- Reset takes effect on the first rising edge with rst=0. Outputs are valid zero from that edge onward. Reset asserted mid-stall or mid-accumulate discards all state, with no residue in hilo_o or cnt_o.
- Flush beats stall: flush with stall_mem=1 still clears the payload on that edge.
- Bubble lasts exactly as many cycles as stall_ex=1 with stall_mem=0. Each such edge writes NOP.
- Multi-cycle madd/msub:
  - On cycle k with stall_ex=1: hilo_o and cnt_o at edge k equal hilo_i and cnt_i.
  - On the releasing edge (stall_ex=0): payload advances, and hilo_o and cnt_o return to 0.
- Back-to-back advances: a new payload on every edge. No dead cycles.

## Test plan
- Reset: drive rst=0 for 2 cycles with all ex_* inputs = all-ones. All outputs must be 0. Release rst; the first advance edge gives mem_valid=1 and mem_wdata=ex_wdata.
- Advance stream: ex_wdata=0x11111111, then 0x22222222, then 0x33333333 on consecutive edges, with wd 1, 2, 3 and wreg=1. mem_wdata follows one cycle later each cycle, and mem_valid stays 1.
- Bubble: stall_ex=1, stall_mem=0 for 2 cycles with ex_wreg=1, ex_wd=7. mem_wreg=0, mem_wd=0 and mem_valid=0 on both edges. Release: mem_wd=7 on the next edge.
- Hold: load mem_wdata=0xDEADBEEF, then stall_mem=1 and stall_ex=1 for 3 cycles while ex_wdata changes. mem_wdata stays 0xDEADBEEF and mem_valid stays 1.
- Accumulate: stall_ex=1 with hilo_i=0x0000000100000002, cnt_i=1. On the next edge hilo_o=0x0000000100000002 and cnt_o=1. Set stall_ex=0: on the next edge hilo_o=0 and cnt_o=0.
- Flush vs stall: with payload loaded, flush=1 and stall_mem=1 together. All mem_* outputs, mem_valid, hilo_o and cnt_o must be 0 on that edge.
